// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IO_WAIT = 2'd1,
    HALT    = 2'd2
  } seq_state_e;

  // The RAS count spans 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO with push, pop and swap-top; pushes are dropped when full.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         swap,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CNT_W = ras_cnt_w(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        wr_ptr;
  logic                    wr_en;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign wr_en  = (push && !full) || (swap && !empty);
  // Push writes the next free slot; swap overwrites the current top.
  assign wr_ptr = push ? cnt : cnt - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_en && wr_ptr == CNT_W'(i)) mem[i] <= wr_data;
      if (push && !full)
        cnt <= cnt + CNT_W'(1);
      else if (pop && !empty)
        cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (cnt == CNT_W'(i + 1)) top = mem[i];
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register with RUN/IO_WAIT/HALT stall control and a hardware return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(1),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] next_pc,
  input  logic            call,
  input  logic            ret,
  input  logic            brk,
  input  logic            resume,
  input  logic            in_req,
  input  logic            out_req,
  input  logic            io_release,
  output logic [PC_W-1:0] pc,
  output logic            io_wait,
  output logic            halted,
  output logic            ras_ovf,
  output logic            ras_unf
);

  seq_state_e      state, state_nxt;
  logic [PC_W-1:0] pc_nxt, pc_inc, ras_top;
  logic            push, pop, swap, ras_full, ras_empty;
  logic            set_ovf, set_unf;

  assign pc_inc  = pc + PC_W'(1);
  assign io_wait = (state == IO_WAIT);
  assign halted  = (state == HALT);

  pc_ras #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .swap    (swap),
    .wr_data (pc_inc),
    .top     (ras_top),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_VEC;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ras_ovf <= ras_ovf | set_ovf;
      ras_unf <= ras_unf | set_unf;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    swap      = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    unique case (state)
      RUN: begin
        if (brk) begin
          state_nxt = HALT;
        end else if ((in_req || out_req) && !io_release) begin
          state_nxt = IO_WAIT;
        end else if (ret && !ras_empty) begin
          // Plain return pops; call+return reuses the slot for the new link.
          pc_nxt = ras_top;
          pop    = !call;
          swap   = call;
        end else begin
          pc_nxt  = next_pc;
          set_unf = ret;
          if (call) begin
            push    = !ras_full;
            set_ovf = ras_full;
          end
        end
      end
      IO_WAIT: if (io_release) state_nxt = RUN;
      HALT:    if (resume)     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default build, RESET_VEC=0x100 build and an 8-bit PC build.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, call, ret, brk, resume, in_req, out_req, io_release;
  logic [31:0] next_pc;
  logic [31:0] pc_a, pc_b;
  logic [7:0]  pc_c;
  logic        io_wait_a, halted_a, ovf_a, unf_a;
  logic        io_wait_b, halted_b, ovf_b, unf_b;
  logic        io_wait_c, halted_c, ovf_c, unf_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(32), .RESET_VEC(32'd1), .RAS_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .call(call), .ret(ret), .brk(brk),
    .resume(resume), .in_req(in_req), .out_req(out_req), .io_release(io_release),
    .pc(pc_a), .io_wait(io_wait_a), .halted(halted_a), .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  pc_sequencer #(.PC_W(32), .RESET_VEC(32'h100), .RAS_DEPTH(4)) u_dut_rv (
    .clk(clk), .reset(reset), .next_pc(next_pc), .call(call), .ret(ret), .brk(brk),
    .resume(resume), .in_req(in_req), .out_req(out_req), .io_release(io_release),
    .pc(pc_b), .io_wait(io_wait_b), .halted(halted_b), .ras_ovf(ovf_b), .ras_unf(unf_b)
  );

  pc_sequencer #(.PC_W(8), .RESET_VEC(8'd1), .RAS_DEPTH(4)) u_dut_w8 (
    .clk(clk), .reset(reset), .next_pc(next_pc[7:0]), .call(call), .ret(ret), .brk(brk),
    .resume(resume), .in_req(in_req), .out_req(out_req), .io_release(io_release),
    .pc(pc_c), .io_wait(io_wait_c), .halted(halted_c), .ras_ovf(ovf_c), .ras_unf(unf_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    call = 0; ret = 0; brk = 0; resume = 0; in_req = 0; out_req = 0; io_release = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    idle();
    next_pc = 0;
    @(negedge clk);

    // 1. reset values and straight-line sequencing
    reset = 1; brk = 1; step();
    chk("rst_pc", pc_a, 32'd1);
    chk("rst_pc_vec100", pc_b, 32'h100);
    chk("rst_pc_w8", {24'd0, pc_c}, 32'd1);
    chk("rst_halted", {31'd0, halted_a}, 32'd0);
    chk("rst_io_wait", {31'd0, io_wait_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
    chk("rst_unf", {31'd0, unf_a}, 32'd0);
    reset = 0; brk = 0;
    for (int i = 2; i <= 4; i++) begin
      next_pc = i; step();
      chk("seq_pc", pc_a, i);
    end

    // 2. I/O stall, release, and same-cycle release
    next_pc = 5; step();
    out_req = 1; next_pc = 6; step();
    chk("io_enter_wait", {31'd0, io_wait_a}, 32'd1);
    chk("io_enter_pc", pc_a, 32'd5);
    out_req = 0;
    for (int i = 0; i < 10; i++) begin
      next_pc = 100 + i; step();
      chk("io_hold_pc", pc_a, 32'd5);
    end
    io_release = 1; next_pc = 8; step();
    chk("io_rel_wait", {31'd0, io_wait_a}, 32'd0);
    chk("io_rel_pc", pc_a, 32'd5);
    io_release = 0; next_pc = 9; step();
    chk("io_after_pc", pc_a, 32'd9);
    out_req = 1; io_release = 1; next_pc = 10; step();
    chk("io_same_wait", {31'd0, io_wait_a}, 32'd0);
    chk("io_same_pc", pc_a, 32'd10);
    idle();
    in_req = 1; next_pc = 11; step();
    chk("in_wait", {31'd0, io_wait_a}, 32'd1);
    in_req = 0; brk = 1; call = 1; next_pc = 12; step();
    chk("io_ign_brk_wait", {31'd0, io_wait_a}, 32'd1);
    chk("io_ign_brk_halt", {31'd0, halted_a}, 32'd0);
    chk("io_ign_pc", pc_a, 32'd10);
    idle(); io_release = 1; step();
    chk("in_rel_pc", pc_a, 32'd10);
    idle();

    // 3. break with call ignored, resume, reset out of HALT
    next_pc = 7; step();
    brk = 1; call = 1; next_pc = 8; step();
    chk("brk_halted", {31'd0, halted_a}, 32'd1);
    chk("brk_pc", pc_a, 32'd7);
    idle(); ret = 1; next_pc = 50; step();
    chk("halt_hold_pc", pc_a, 32'd7);
    chk("halt_hold_st", {31'd0, halted_a}, 32'd1);
    chk("halt_ign_ret_unf", {31'd0, unf_a}, 32'd0);
    idle(); resume = 1; step();
    chk("resume_halted", {31'd0, halted_a}, 32'd0);
    chk("resume_pc", pc_a, 32'd7);
    idle(); ret = 1; next_pc = 33; step();
    chk("brk_call_dropped_pc", pc_a, 32'd33);
    chk("brk_call_dropped_unf", {31'd0, unf_a}, 32'd1);
    idle(); brk = 1; step();
    chk("halt_again", {31'd0, halted_a}, 32'd1);
    reset = 1; step(); reset = 0; idle();
    chk("halt_rst_pc", pc_a, 32'd1);
    chk("halt_rst_halted", {31'd0, halted_a}, 32'd0);
    chk("halt_rst_unf", {31'd0, unf_a}, 32'd0);

    // 4. fill, overflow, drain, underflow
    next_pc = 10; step();
    call = 1;
    for (int i = 2; i <= 5; i++) begin
      next_pc = 10 * i; step();
      chk("call_pc", pc_a, 10 * i);
    end
    chk("fill_no_ovf", {31'd0, ovf_a}, 32'd0);
    next_pc = 60; step();
    chk("ovf_pc", pc_a, 32'd60);
    chk("ovf_flag", {31'd0, ovf_a}, 32'd1);
    call = 0; ret = 1; next_pc = 0;
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("ret_pc", pc_a, 10 * i + 1);
    end
    chk("drain_no_unf", {31'd0, unf_a}, 32'd0);
    next_pc = 99; step();
    chk("unf_pc", pc_a, 32'd99);
    chk("unf_flag", {31'd0, unf_a}, 32'd1);
    ret = 0; next_pc = 100; step();
    chk("flags_sticky_ovf", {31'd0, ovf_a}, 32'd1);
    chk("flags_sticky_unf", {31'd0, unf_a}, 32'd1);

    // 5. call+ret swap, call+ret on empty, 8-bit wrap
    do_reset();
    next_pc = 10; step();
    call = 1; next_pc = 60; step();
    chk("swap_setup_pc", pc_a, 32'd60);
    ret = 1; next_pc = 77; step();
    chk("swap_pc", pc_a, 32'd11);
    call = 0; next_pc = 78; step();
    chk("swap_top", pc_a, 32'd61);
    chk("swap_no_unf", {31'd0, unf_a}, 32'd0);
    next_pc = 88; step();
    chk("swap_cnt_pc", pc_a, 32'd88);
    chk("swap_cnt_unf", {31'd0, unf_a}, 32'd1);
    idle(); do_reset();
    next_pc = 40; step();
    call = 1; ret = 1; next_pc = 45; step();
    chk("cr_empty_pc", pc_a, 32'd45);
    chk("cr_empty_unf", {31'd0, unf_a}, 32'd1);
    call = 0; next_pc = 46; step();
    chk("cr_empty_push", pc_a, 32'd41);
    idle(); do_reset();
    next_pc = 255; step();
    chk("w8_pc", {24'd0, pc_c}, 32'd255);
    call = 1; next_pc = 3; step();
    chk("w8_call_pc", {24'd0, pc_c}, 32'd3);
    call = 0; ret = 1; next_pc = 9; step();
    chk("w8_wrap_ret", {24'd0, pc_c}, 32'd0);
    chk("w32_no_wrap_ret", pc_a, 32'd256);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the single-issue core. It replaces the flat PC register and adds an explicit RUN / IO_WAIT / HALT state machine for break and I/O stalls, plus a hardware return-address stack (RAS) for call/return. It sits between the next-PC mux in the datapath and the instruction memory address port.

Parameters:
PC_W, 32, PC width in bits; all PC arithmetic is modulo 2^PC_W.
RESET_VEC, 1, PC value loaded on reset.
RAS_DEPTH, 4, number of RAS entries; must be at least 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  reset, synchronous, active-high.
next_pc  in  PC_W  next PC from the datapath (sequential, branch or jump target).
call  in  1  current instruction is a call; push return address.
ret  in  1  current instruction is a return; pop return address.
brk  in  1  break instruction; enter HALT.
resume  in  1  leave HALT.
in_req  in  1  I/O input instruction; enter IO_WAIT.
out_req  in  1  I/O output instruction; enter IO_WAIT.
io_release  in  1  operator/switch acknowledge; leave IO_WAIT.
pc  out  PC_W  current PC.
io_wait  out  1  high while state is IO_WAIT.
halted  out  1  high while state is HALT.
ras_ovf  out  1  sticky flag: push attempted while the RAS was full.
ras_unf  out  1  sticky flag: pop attempted while the RAS was empty.

Behaviour:
- Reset (any state, any cycle, including mid-stall):
  - pc <= RESET_VEC; state <= RUN.
  - RAS count <= 0; ras_ovf and ras_unf <= 0.
  - Reset overrides every other input in the same cycle.
- io_wait and halted are decoded directly from state, with no extra latency.
- RUN, evaluated in priority order each edge:
  1. brk: state <= HALT; pc holds; call/ret are ignored.
  2. in_req or out_req, with io_release low: state <= IO_WAIT; pc holds; call/ret are ignored.
  3. in_req or out_req, with io_release high in the same cycle: no stall; continue with 4.
  4. PC update:
     - ret only, RAS not empty: pc <= top; pop.
     - ret only, RAS empty: pc <= next_pc; ras_unf <= 1.
     - call only, RAS not full: pc <= next_pc; push pc+1.
     - call only, RAS full: pc <= next_pc; push dropped; ras_ovf <= 1; contents unchanged.
     - call and ret together, RAS not empty: pc <= top; top replaced by pc+1; count unchanged.
     - call and ret together, RAS empty: treated as call only; ras_unf <= 1.
     - Neither call nor ret: pc <= next_pc.
- IO_WAIT:
  - pc and RAS hold.
  - io_release: state <= RUN; pc still holds on that edge, so it advances on the next edge.
  - brk, call, ret, in_req and out_req are ignored.
- HALT:
  - pc and RAS hold.
  - resume: state <= RUN; pc holds on that edge.
  - All other inputs are ignored.
- Arithmetic: pc+1 wraps, e.g. 2^PC_W-1 -> 0. The RAS count ranges 0..RAS_DEPTH and needs $clog2(RAS_DEPTH+1) bits.
- Flags: ras_ovf and ras_unf are cleared only by reset.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum {RUN, IO_WAIT, HALT} as a 2-bit type;
  - the helper function computing the RAS count width.
- One natural sub-module: pc_ras. It is a LIFO of RAS_DEPTH x PC_W entries with push, pop and swap operations and full/empty outputs, and it drops a push when full.
- FSM and PC register stay in pc_sequencer.

Test Plan:
1. reset high 1 cycle, then next_pc=2,3,4 -> pc=1 after reset, then 2,3,4 on successive edges. With RESET_VEC=0x100, pc=0x100.
2. pc=5, out_req=1 -> IO_WAIT; io_wait=1; pc holds 5 across 10 cycles with changing next_pc. io_release=1 -> RUN with pc=5. Next edge: pc=next_pc. Repeat with out_req and io_release in the same cycle -> no stall; pc=next_pc.
3. pc=7, brk=1 and call=1 -> HALT; pc=7; RAS count 0. resume -> RUN. Reset during HALT -> pc=RESET_VEC; halted=0.
4. RAS_DEPTH=4: call at pc=10,20,30,40 with targets 20,30,40,50 -> stack holds 11,21,31,41. A 5th call at pc=50 -> ras_ovf=1; stack unchanged. ret x4 -> pc=41,31,21,11. A 5th ret with next_pc=99 -> pc=99; ras_unf=1.
5. Stack top=11, pc=60, call and ret together -> pc=11; top=61; count unchanged. PC_W=8, pc=255, call -> pushed value 0.
